// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a 2-FF input synchroniser feeding a first-word-fall-through byte FIFO.
// Latency: byte visible the clk after the stop-bit tick; the receiver never stalls, full FIFO sets overrun.
module uart_rx_fifo #(
    parameter int CLK_HZ  = 40000000,
    parameter int SCLK_HZ = 115200,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             uart_rxd,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [DEPTH:0]   count,
    output logic             overrun,
    output logic             frame_err,
    input  logic             err_clr
);

    localparam int DIV  = CLK_HZ / SCLK_HZ;
    localparam int CW   = $clog2(DIV + 1);
    localparam int NENT = 1 << DEPTH;
    localparam logic [CW-1:0]  CNT_BIT  = CW'(DIV - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [DEPTH:0] FIFO_MAX = (DEPTH + 1)'(NENT);
    localparam logic [DEPTH:0] FIFO_ONE = (DEPTH + 1)'(1);
    localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t            r_state;
    logic              r_sync1;
    logic              r_sync2;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_push;
    logic              r_ferr_set;

    logic [7:0]        r_mem [NENT];
    logic [DEPTH-1:0]  r_wptr;
    logic [DEPTH-1:0]  r_rptr;
    logic [DEPTH:0]    r_count;
    logic              r_overrun;
    logic              r_frame_err;

    logic w_rxs;
    logic w_tick;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;
    logic w_ovr_set;

    assign w_rxs  = r_sync2;
    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_push     <= 1'b0;
            r_ferr_set <= 1'b0;
        end else begin
            r_sync1    <= uart_rxd;
            r_sync2    <= r_sync1;
            r_push     <= 1'b0;
            r_ferr_set <= 1'b0;
            if ((r_state == S_START || r_state == S_DATA || r_state == S_STOP) && !w_tick) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_cnt   <= CNT_HALF;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (!w_rxs) begin
                            r_cnt   <= CNT_BIT;
                            r_bit   <= '0;
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_rxs, r_shift[7:1]};
                        r_cnt   <= CNT_BIT;
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (w_rxs) begin
                            r_push  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_ferr_set <= 1'b1;
                            r_state    <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A pop on an empty FIFO is masked, so push-while-empty simply lands the byte.
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FIFO_MAX);
    assign w_pop     = !w_empty && rd_ready;
    assign w_wr      = r_push && (!w_full || w_pop);
    assign w_ovr_set = r_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + FIFO_ONE;
                2'b01:   r_count <= r_count - FIFO_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (err_clr) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
            if (r_ferr_set) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign rd_valid  = !w_empty;
    assign rd_data   = w_empty ? 8'h00 : r_mem[r_rptr];
    assign count     = r_count;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial stimulus, expected bytes queued at send, compared on pop.
// Runs a reduced clock (DIV=35 clocks/bit, truncated from 4.05 MHz / 115200) to keep the run short.
module tb_uart_rx_fifo;

    localparam int CLK_HZ  = 4050000;
    localparam int SCLK_HZ = 115200;
    localparam int DEPTH   = 4;
    localparam int DIV     = 35;

    logic           clk;
    logic           reset;
    logic           uart_rxd;
    logic [7:0]     rd_data;
    logic           rd_valid;
    logic           rd_ready;
    logic [DEPTH:0] count;
    logic           overrun;
    logic           frame_err;
    logic           err_clr;

    int         total;
    int         bad;
    logic [7:0] exp_q[$];
    bit         follow;

    uart_rx_fifo #(
        .CLK_HZ  (CLK_HZ),
        .SCLK_HZ (SCLK_HZ),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rxd  (uart_rxd),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .count     (count),
        .overrun   (overrun),
        .frame_err (frame_err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // In follow mode rd_ready mirrors the pending push, forcing pop and push into the same edge.
    task automatic send_bit(input logic v);
        uart_rxd = v;
        repeat (DIV) begin
            @(negedge clk);
            if (follow) rd_ready = dut.r_push;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
                else chk("pop_data", int'(rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total    = 0;
        bad      = 0;
        follow   = 1'b0;
        reset    = 1'b1;
        uart_rxd = 1'b1;
        rd_ready = 1'b0;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_data", int'(rd_data), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        reset = 1'b0;
        idle(2 * DIV);

        // 1: two stored bytes, FWFT head, drain
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        exp_q.push_back(8'hA3);
        send_byte(8'hA3, 1'b1);
        idle(5);
        chk("t1_count", int'(count), 2);
        chk("t1_head", int'(rd_data), 'h55);
        pop_one();
        chk("t1_head2", int'(rd_data), 'hA3);
        pop_one();
        chk("t1_empty", int'(rd_valid), 0);

        // 2: short low glitch is not a start bit
        uart_rxd = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        idle(2 * DIV);
        chk("t2_count", int'(count), 0);
        chk("t2_frame_err", int'(frame_err), 0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        idle(5);
        chk("t2_after_count", int'(count), 1);
        pop_one();

        // 3: framing error, held break, recovery, err_clr
        send_byte(8'h3C, 1'b0);
        repeat (5) send_bit(1'b0);
        idle(2 * DIV);
        chk("t3_frame_err", int'(frame_err), 1);
        chk("t3_count", int'(count), 0);
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        idle(5);
        chk("t3_count2", int'(count), 1);
        chk("t3_head", int'(rd_data), 'h12);
        chk("t3_sticky", int'(frame_err), 1);
        pulse_clr();
        chk("t3_clr", int'(frame_err), 0);
        chk("t3_clr_fifo", int'(count), 1);
        pop_one();

        // 4: overflow keeps oldest 16 bytes
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        idle(5);
        chk("t4_count", int'(count), 16);
        chk("t4_overrun", int'(overrun), 1);
        chk("t4_head", int'(rd_data), 0);
        rd_ready = 1'b1;
        for (int i = 0; i < 40 && rd_valid; i++) @(negedge clk);
        rd_ready = 1'b0;
        chk("t4_drained", int'(rd_valid), 0);
        chk("t4_queue", exp_q.size(), 0);
        chk("t4_sticky", int'(overrun), 1);
        pulse_clr();
        chk("t4_clr", int'(overrun), 0);

        // 5: reset during bit 4 discards everything
        exp_q.push_back(8'hC1);
        send_byte(8'hC1, 1'b1);
        exp_q.push_back(8'h2D);
        send_byte(8'h2D, 1'b1);
        idle(5);
        chk("t5_pre_count", int'(count), 2);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h99 >> i));
        uart_rxd = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("t5_count", int'(count), 0);
        chk("t5_valid", int'(rd_valid), 0);
        chk("t5_overrun", int'(overrun), 0);
        chk("t5_frame_err", int'(frame_err), 0);
        reset = 1'b0;
        idle(2 * DIV);
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, 1'b1);
        idle(5);
        chk("t5_count2", int'(count), 1);
        chk("t5_head", int'(rd_data), 'h7E);
        pop_one();

        // 6a: back-to-back with rd_ready held high
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'hE0 + 8'(i));
            send_byte(8'hE0 + 8'(i), 1'b1);
            chk("t6a_count", int'(count), 0);
        end
        rd_ready = 1'b0;

        // 6b: push coincides with pop while count=1
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        idle(3);
        chk("t6b_count0", int'(count), 1);
        follow = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'h90 + 8'(i));
            send_byte(8'h90 + 8'(i), 1'b1);
            chk("t6b_count", int'(count), 1);
        end
        follow   = 1'b0;
        rd_ready = 1'b0;
        idle(3);
        chk("t6b_head", int'(rd_data), 'h92);
        pop_one();
        chk("t6b_empty", int'(rd_valid), 0);
        chk("end_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
